// File: rtl/eth_rx_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module   : eth_rx_frame_fifo
// Brief    : Store-and-forward receive frame FIFO for the MII MAC RX stream.
//            Whole frames are buffered, committed on tlast and replayed on a
//            back-pressurable AXI-Stream master. Overflowing frames are
//            discarded whole.
//            Build option ETH_RX_FIFO_DROP_BAD_EN: when defined, frames that
//            end with tuser=1 are discarded and m_axis_tuser is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module eth_rx_frame_fifo #(
  parameter int DEPTH = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       status_overflow,
  output logic       status_bad_frame,
  output logic       status_good_frame
);

  localparam int             c_aw    = $clog2(DEPTH);
  localparam logic [c_aw:0]  c_depth = (c_aw + 1)'(DEPTH);
  localparam logic [c_aw:0]  c_one   = (c_aw + 1)'(1);
`ifdef ETH_RX_FIFO_DROP_BAD_EN
  localparam int             c_ram_w    = 9;
  localparam logic           c_drop_bad = 1'b1;
`else
  localparam int             c_ram_w    = 10;
  localparam logic           c_drop_bad = 1'b0;
`endif

  // Byte storage; the tuser bit only exists when bad frames are forwarded
  logic [c_ram_w-1:0] r_ram [DEPTH];

  logic [c_aw:0]      r_wr_ptr_cur;  // speculative write position
  logic [c_aw:0]      r_wr_ptr;      // committed write position
  logic [c_aw:0]      r_rd_ptr;      // read position
  logic               r_drop_frame;  // current frame has lost a byte
  logic               r_overflow;
  logic               r_bad_frame;
  logic               r_good_frame;
  logic               r_out_valid;
  logic [7:0]         r_out_data;
  logic               r_out_last;

  logic               w_full;
  logic               w_drop_byte;
  logic               w_wr_en;
  logic               w_eof;
  logic [c_aw:0]      w_wr_ptr_inc;
  logic               w_rd_en;
  logic [c_ram_w-1:0] w_wr_word;
  logic [c_ram_w-1:0] w_rd_word;

  // Full is judged on registered pointers only, so a same-cycle read never
  // frees space for the byte arriving on that edge.
  assign w_full       = (r_wr_ptr_cur - r_rd_ptr) == c_depth;
  assign w_drop_byte  = s_axis_tvalid && (w_full || r_drop_frame);
  assign w_wr_en      = s_axis_tvalid && !w_full && !r_drop_frame;
  assign w_eof        = s_axis_tvalid && s_axis_tlast;
  assign w_wr_ptr_inc = r_wr_ptr_cur + c_one;

  // The reader only ever sees committed bytes (pre-edge r_wr_ptr)
  assign w_rd_en   = (r_rd_ptr != r_wr_ptr) && (!r_out_valid || m_axis_tready);
  assign w_rd_word = r_ram[r_rd_ptr[c_aw-1:0]];

`ifdef ETH_RX_FIFO_DROP_BAD_EN
  assign w_wr_word    = {s_axis_tlast, s_axis_tdata};
  assign m_axis_tuser = 1'b0;
`else
  logic r_out_user;

  assign w_wr_word    = {s_axis_tuser, s_axis_tlast, s_axis_tdata};
  assign m_axis_tuser = r_out_user;

  // Bad-frame marker travels with the byte it was stored alongside
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_user <= 1'b0;
    end else if (w_rd_en) begin
      r_out_user <= w_rd_word[9];
    end
  end
`endif

  // Storage write; the array carries no reset so it can map onto RAM
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_ram[r_wr_ptr_cur[c_aw-1:0]] <= w_wr_word;
    end
  end

  // Write pointers, frame drop tracking and registered status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr_cur <= '0;
      r_wr_ptr     <= '0;
      r_drop_frame <= 1'b0;
      r_overflow   <= 1'b0;
      r_bad_frame  <= 1'b0;
      r_good_frame <= 1'b0;
    end else begin
      r_overflow   <= 1'b0;
      r_bad_frame  <= 1'b0;
      r_good_frame <= 1'b0;
      if (w_wr_en) begin
        r_wr_ptr_cur <= w_wr_ptr_inc;
      end
      if (w_drop_byte) begin
        r_drop_frame <= 1'b1;
      end
      if (w_eof) begin
        if (w_drop_byte) begin
          // Frame lost a byte somewhere: rewind and report overflow
          r_wr_ptr_cur <= r_wr_ptr;
          r_drop_frame <= 1'b0;
          r_overflow   <= 1'b1;
        end else if (c_drop_bad && s_axis_tuser) begin
          r_wr_ptr_cur <= r_wr_ptr;
          r_bad_frame  <= 1'b1;
        end else begin
          // The tlast byte itself was written this edge, so commit past it
          r_wr_ptr     <= w_wr_ptr_inc;
          r_good_frame <= 1'b1;
          r_bad_frame  <= s_axis_tuser;
        end
      end
    end
  end

  // Single output register loaded whenever it is empty or being consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
      r_out_last  <= 1'b0;
    end else if (w_rd_en) begin
      r_rd_ptr    <= r_rd_ptr + c_one;
      r_out_valid <= 1'b1;
      r_out_data  <= w_rd_word[7:0];
      r_out_last  <= w_rd_word[8];
    end else if (m_axis_tready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign m_axis_tdata      = r_out_data;
  assign m_axis_tvalid     = r_out_valid;
  assign m_axis_tlast      = r_out_last;
  assign status_overflow   = r_overflow;
  assign status_bad_frame  = r_bad_frame;
  assign status_good_frame = r_good_frame;

endmodule
`default_nettype wire
